// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: steps each instruction through fetch, decode, execute,
// memory and writeback, driving datapath enables/selects from the state and latched class.
module multicycle_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [9:0]  code,
   input  logic        branch_taken,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        addr_sel,
   output logic        ir_we,
   output logic        pc_we,
   output logic        pc_sel,
   output logic        alu_sel_a,
   output logic        alu_sel_b,
   output logic        rf_we,
   output logic [1:0]  wb_sel,
   output logic        illegal,
   output logic [31:0] retired
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      TRAP   = 3'd6
   } state_t;

   state_t      state, state_nxt;
   logic [9:0]  cls;
   logic        code_onehot;

   logic is_j, is_jalr, is_auipc, is_b, is_s, is_load, is_csr, is_wb_class;

   assign code_onehot = (code != 10'd0) && ((code & (code - 10'd1)) == 10'd0);

   assign is_j        = cls[0];
   assign is_jalr     = cls[1];
   assign is_auipc    = cls[3];
   assign is_b        = cls[4];
   assign is_s        = cls[6];
   assign is_load     = cls[8];
   assign is_csr      = cls[9];
   // Classes that finish through the register-file writeback state
   assign is_wb_class = |{cls[9], cls[7], cls[5], cls[3:0]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cls <= 10'd0;
      else if (state == DECODE && code_onehot)
         cls <= code;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         retired <= 32'd0;
      else if (pc_we)
         retired <= retired + 32'd1;
   end

   always_comb begin
      state_nxt = state;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      addr_sel  = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = 1'b0;
      alu_sel_a = 1'b0;
      alu_sel_b = 1'b0;
      rf_we     = 1'b0;
      wb_sel    = 2'd0;
      illegal   = 1'b0;

      case (state)
         IDLE: state_nxt = FETCH;
         FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_we     = 1'b1;
               state_nxt = DECODE;
            end
         end
         DECODE: state_nxt = code_onehot ? EXEC : TRAP;
         EXEC: begin
            if (is_s || is_load)
               state_nxt = MEM;
            else if (is_b) begin
               pc_we     = 1'b1;
               pc_sel    = branch_taken;
               state_nxt = FETCH;
            end else if (is_wb_class)
               state_nxt = WB;
            else
               state_nxt = TRAP;
         end
         MEM: begin
            mem_req  = 1'b1;
            addr_sel = 1'b1;
            mem_we   = is_s;
            if (mem_ready) begin
               if (is_s) begin
                  pc_we     = 1'b1;
                  state_nxt = FETCH;
               end else
                  state_nxt = WB;
            end
         end
         WB: begin
            rf_we     = 1'b1;
            pc_we     = 1'b1;
            pc_sel    = is_j | is_jalr;
            if (is_load)
               wb_sel = 2'd1;
            else if (is_j || is_jalr)
               wb_sel = 2'd2;
            else if (is_csr)
               wb_sel = 2'd3;
            state_nxt = FETCH;
         end
         TRAP: illegal = 1'b1;
         default: state_nxt = IDLE;
      endcase

      // Operand selects only matter while the datapath is working on the latched class
      if (state == EXEC || state == MEM || state == WB) begin
         alu_sel_a = is_j | is_auipc | is_csr;
         alu_sel_b = |{cls[9:6], cls[3:0]};
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle vector table for legal instruction streams,
// plus hand sequences for illegal codes, reset mid-store and counter wrap.
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  code;
   logic        branch_taken;
   logic        mem_ready;
   logic        mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel;
   logic        alu_sel_a, alu_sel_b, rf_we, illegal;
   logic [1:0]  wb_sel;
   logic [31:0] retired;

   int n_chk  = 0;
   int n_fail = 0;

   localparam logic [9:0] C_J = 10'h001, C_JALR = 10'h002, C_AUIPC = 10'h008, C_B = 10'h010;
   localparam logic [9:0] C_R = 10'h020, C_S = 10'h040, C_LOAD = 10'h100, C_CSR = 10'h200;

   typedef struct {
      logic [9:0]  code;
      logic        bt;
      logic        rdy;
      logic [11:0] outs;
      logic [31:0] ret;
   } vec_t;

   vec_t vt[64];
   int   nv = 0;

   multicycle_ctrl dut (
      .clk(clk), .reset(reset), .code(code), .branch_taken(branch_taken),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
      .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .alu_sel_a(alu_sel_a),
      .alu_sel_b(alu_sel_b), .rf_we(rf_we), .wb_sel(wb_sel), .illegal(illegal),
      .retired(retired)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] o(input logic mr, input logic mw, input logic as_,
                                     input logic ir, input logic pw, input logic ps,
                                     input logic a, input logic b, input logic rf,
                                     input logic [1:0] wb, input logic il);
      return {mr, mw, as_, ir, pw, ps, a, b, rf, wb, il};
   endfunction

   function automatic logic [11:0] outs_now();
      return {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, alu_sel_a, alu_sel_b,
              rf_we, wb_sel, illegal};
   endfunction

   task automatic add(input logic [9:0] c, input logic bt, input logic rdy,
                      input logic [11:0] ex, input logic [31:0] r);
      vt[nv] = '{code: c, bt: bt, rdy: rdy, outs: ex, ret: r};
      nv++;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic reset_dut();
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic illegal_run(input logic [9:0] c, input string tag);
      reset_dut();
      code = c; mem_ready = 1'b1;
      next_cyc();                // FETCH
      next_cyc();                // DECODE
      #1 chk({tag, " illegal low in DECODE"}, {31'd0, illegal}, 32'd0);
      next_cyc();                // TRAP from here on
      for (int k = 0; k < 20; k++) begin
         code = C_R;
         #1;
         chk($sformatf("%s illegal cyc%0d", tag, k), {31'd0, illegal}, 32'd1);
         chk($sformatf("%s mem_req cyc%0d", tag, k), {31'd0, mem_req}, 32'd0);
         chk($sformatf("%s retired cyc%0d", tag, k), retired, 32'd0);
         next_cyc();
      end
   endtask

   initial begin
      reset = 1'b1; code = 10'd0; branch_taken = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("reset outputs", {20'd0, outs_now()}, 32'd0);
      chk("reset retired", retired, 32'd0);

      // Table: three R-type, LOAD with two waits, FETCH wait, B taken/not, S, CSR, JALR, AUIPC
      add(C_R, 0, 1, o(0,0,0,0,0,0,0,0,0,0,0), 0);                 // IDLE
      for (int k = 0; k < 3; k++) begin
         add(C_R, 0, 1, o(1,0,0,1,0,0,0,0,0,0,0), k);              // FETCH
         add(C_R, 0, 1, o(0,0,0,0,0,0,0,0,0,0,0), k);              // DECODE
         add(C_R, 1, 1, o(0,0,0,0,0,0,0,0,0,0,0), k);              // EXEC
         add(C_R, 0, 1, o(0,0,0,0,1,0,0,0,1,0,0), k);              // WB
      end
      add(C_LOAD, 0, 1, o(1,0,0,1,0,0,0,0,0,0,0), 3);
      add(C_LOAD, 0, 1, o(0,0,0,0,0,0,0,0,0,0,0), 3);
      add(C_LOAD, 0, 1, o(0,0,0,0,0,0,0,1,0,0,0), 3);
      add(C_LOAD, 0, 0, o(1,0,1,0,0,0,0,1,0,0,0), 3);              // MEM wait
      add(C_LOAD, 0, 0, o(1,0,1,0,0,0,0,1,0,0,0), 3);              // MEM wait
      add(C_LOAD, 0, 1, o(1,0,1,0,0,0,0,1,0,0,0), 3);
      add(C_LOAD, 0, 1, o(0,0,0,0,1,0,0,1,1,1,0), 3);              // WB
      add(C_B, 0, 0, o(1,0,0,0,0,0,0,0,0,0,0), 4);                 // FETCH wait
      add(C_B, 0, 1, o(1,0,0,1,0,0,0,0,0,0,0), 4);
      add(C_B, 0, 1, o(0,0,0,0,0,0,0,0,0,0,0), 4);
      add(C_B, 1, 1, o(0,0,0,0,1,1,0,0,0,0,0), 4);                 // EXEC taken
      add(C_B, 0, 1, o(1,0,0,1,0,0,0,0,0,0,0), 5);
      add(C_B, 1, 1, o(0,0,0,0,0,0,0,0,0,0,0), 5);
      add(C_B, 0, 1, o(0,0,0,0,1,0,0,0,0,0,0), 5);                 // EXEC not taken
      add(C_S, 0, 1, o(1,0,0,1,0,0,0,0,0,0,0), 6);
      add(C_S, 0, 1, o(0,0,0,0,0,0,0,0,0,0,0), 6);
      add(C_S, 1, 1, o(0,0,0,0,0,0,0,1,0,0,0), 6);                 // EXEC, bt ignored
      add(C_S, 0, 1, o(1,1,1,0,1,0,0,1,0,0,0), 6);                 // MEM store done
      add(C_CSR, 0, 1, o(1,0,0,1,0,0,0,0,0,0,0), 7);
      add(C_CSR, 0, 1, o(0,0,0,0,0,0,0,0,0,0,0), 7);
      add(C_CSR, 0, 1, o(0,0,0,0,0,0,1,1,0,0,0), 7);
      add(C_CSR, 0, 1, o(0,0,0,0,1,0,1,1,1,3,0), 7);
      add(C_JALR, 0, 1, o(1,0,0,1,0,0,0,0,0,0,0), 8);
      add(C_JALR, 0, 1, o(0,0,0,0,0,0,0,0,0,0,0), 8);
      add(C_JALR, 0, 1, o(0,0,0,0,0,0,0,1,0,0,0), 8);
      add(C_JALR, 0, 1, o(0,0,0,0,1,1,0,1,1,2,0), 8);
      add(C_AUIPC, 0, 1, o(1,0,0,1,0,0,0,0,0,0,0), 9);
      add(C_AUIPC, 0, 1, o(0,0,0,0,0,0,0,0,0,0,0), 9);
      add(C_J, 0, 1, o(0,0,0,0,0,0,1,1,0,0,0), 9);                 // code change after DECODE
      add(C_J, 0, 1, o(0,0,0,0,1,0,1,1,1,0,0), 9);
      add(C_R, 0, 1, o(1,0,0,1,0,0,0,0,0,0,0), 10);

      reset = 1'b0;
      for (int i = 0; i < nv; i++) begin
         code = vt[i].code; branch_taken = vt[i].bt; mem_ready = vt[i].rdy;
         #1;
         chk($sformatf("row%0d outs", i), {20'd0, outs_now()}, {20'd0, vt[i].outs});
         chk($sformatf("row%0d retired", i), retired, vt[i].ret);
         next_cyc();
      end

      illegal_run(10'b0000000000, "zero code");
      illegal_run(10'b0000100001, "two-hot code");

      // Reset asserted mid-store while waiting in MEM
      reset_dut();
      code = C_S; mem_ready = 1'b1; branch_taken = 1'b0;
      next_cyc(); next_cyc(); next_cyc(); next_cyc();   // FETCH, DECODE, EXEC, MEM
      mem_ready = 1'b0;
      #1 chk("store mem_req", {31'd0, mem_req}, 32'd1);
      chk("store mem_we", {31'd0, mem_we}, 32'd1);
      #1 reset = 1'b1;
      #1 chk("async reset mem_req", {31'd0, mem_req}, 32'd0);
      chk("async reset mem_we", {31'd0, mem_we}, 32'd0);
      chk("async reset retired", retired, 32'd0);
      @(negedge clk);
      reset = 1'b0; mem_ready = 1'b1;
      #1 chk("post reset IDLE", {20'd0, outs_now()}, 32'd0);
      next_cyc();
      #1 chk("post reset FETCH", {20'd0, outs_now()}, {20'd0, o(1,0,0,1,0,0,0,0,0,0,0)});

      // Counter wrap on a JAL
      reset_dut();
      force dut.retired = 32'hFFFF_FFFF;
      code = C_J; mem_ready = 1'b1;
      next_cyc();                                       // FETCH
      release dut.retired;
      #1 chk("wrap preset", retired, 32'hFFFF_FFFF);
      next_cyc();                                       // DECODE
      next_cyc();                                       // EXEC
      #1 chk("jal exec alu_sel_a", {31'd0, alu_sel_a}, 32'd1);
      next_cyc();                                       // WB
      #1 chk("jal wb wb_sel", {30'd0, wb_sel}, 32'd2);
      chk("jal wb pc_sel", {31'd0, pc_sel}, 32'd1);
      chk("jal wb pc_we", {31'd0, pc_we}, 32'd1);
      next_cyc();                                       // FETCH
      #1 chk("retired wrap", retired, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
